patch_readout_streamer: RTL and testbench
=========================================

# patch_readout_streamer

Drains the 4×4 node-patch result grid into a serial valid/ready sample stream for display or host logging. The patch solver writes its grid and raises an iteration flag. This block reads that grid by snapshotting it into a ping-pong buffer pair. It then emits the 16 samples in row-major order, each tagged with row, column, frame markers and iteration number. It sits between a node patch and the downstream video/HPS sink, and absorbs sink back-pressure without stalling the solver.

## Interface
- DATA_W, 18: sample width; signed two's complement, same format as the patch node values.
- CNT_W, 16: iteration counter and drop counter width.
- DECIM, 4: capture decimation ratio; used only when the configuration macro is defined; must be ≥1.

- clock  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- u_2_mid  in  DATA_W ×[3:0][3:0]  patch result grid, indexed [row][col]; sampled only on a capture event.
- iter_flag  in  1  patch iteration-complete flag; may stay high for more than one cycle.
- out_valid  out  1  a sample is presented.
- out_ready  in  1  sink accepts the sample when out_valid & out_ready.
- out_data  out  DATA_W  sample value.
- out_row, out_col  out  2 each  grid coordinates of out_data.
- out_first  out  1  high with sample (0,0).
- out_last  out  1  high with sample (3,3).
- out_iter  out  CNT_W  iteration number of the frame being streamed.
- overflow  out  1  sticky; set on the first dropped frame.
- drop_count  out  CNT_W  dropped frames; saturates at all-ones.

## Operation
- Capture event: iter_flag==1 and iter_flag registered value from the previous cycle ==0, i.e. a rising edge. While reset is active, the registered value is 0.
- iter_cnt increments on every capture event and wraps modulo 2^CNT_W. The frame captured on that event is tagged with the post-increment value, so the first frame after reset is iter 1.
- Buffers: two banks, A and B, each holding 16×DATA_W plus an iter tag and a FULL bit.
- A capture writes the whole grid in one cycle into an empty bank, preferring A, and sets FULL.
- If both banks are FULL after this cycle's release, the frame is dropped: overflow is set and drop_count increments.
- FSM states:
  - IDLE: out_valid=0. If any bank is FULL, go to STREAM. When both are FULL, take the oldest first, judged by iter tag order of arrival; keep a 1-bit "oldest" pointer.
  - STREAM: present bank[idx], with idx 0..15 and row=idx[3:2], col=idx[1:0].
    - On accept with idx<15: idx++.
    - On accept with idx==15: clear that bank's FULL and reset idx to 0. If the other bank is FULL, stay in STREAM on it with no bubble; else go to IDLE.
- Same-cycle release and capture: the release is applied first, so the capture lands in the freed bank and no drop occurs.
- The out_* data/tag fields hold steady while out_valid & ~out_ready. out_valid never drops without an accept, except on reset.
- Reset mid-stream discards both banks and any partial frame with no further output. Reset clears iter_cnt, drop_count, overflow, idx, the FULL bits, and the pointer, and returns the FSM to IDLE.

## Timing
- Reset values: out_valid=0, out_data=0, out_row=0, out_col=0, out_first=0, out_last=0, out_iter=0, overflow=0, drop_count=0.
- Latency: a capture edge seen in cycle T, with the FSM IDLE, gives out_valid=1 with sample (0,0) in cycle T+1.
- Throughput: one sample per cycle with out_ready held high, so one frame every 16 cycles. Back-to-back frames have zero idle cycles.
- All outputs are registered; out_ready has only a register-input path.

## Configuration
- PATCH_READOUT_DECIMATE_EN
  - Defined: a phase counter (0..DECIM-1) advances on every capture event. Only events that occur at phase 0 are written to a bank; the others are ignored and do not count as drops. iter_cnt still counts every event, so streamed out_iter values step by DECIM.
  - Undefined: every capture event is written; the phase logic and DECIM are unused.

## Test plan
- Reset, then grid[r][c]=16r+c and one iter_flag pulse, with out_ready=1 → 16 samples 0..15 in consecutive cycles. First sample in cycle T+1; out_first on (0,0), out_last on (3,3); out_iter=1; then out_valid=0.
- iter_flag held high for 5 cycles → exactly one frame is streamed; iter_cnt advances by 1.
- out_ready=0 for 40 cycles while 3 capture pulses arrive → frames 1 and 2 are buffered and frame 3 is dropped, giving overflow=1 and drop_count=1. After out_ready=1, 32 samples stream with out_iter 1 then 2.
- A capture arrives in the same cycle as acceptance of (3,3) while both banks are FULL → no drop, and the next frame follows with no bubble.
- Reset asserted at idx=7 → out_valid=0 in the next cycle and all counters are 0. No stale samples appear after reset is released.
- With PATCH_READOUT_DECIMATE_EN and DECIM=4, 8 pulses → 2 frames with out_iter 1 and 5; drop_count=0.

Source files
------------

// File: rtl/patch_readout_streamer.sv
// Snapshots the 4x4 patch grid into ping-pong banks on each iter_flag rising edge and streams
// the 16 samples row-major over valid/ready. Optional capture decimation: PATCH_READOUT_DECIMATE_EN.
module patch_readout_streamer #(
    parameter int unsigned DATA_W = 18,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned DECIM  = 4
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [3:0][3:0][DATA_W-1:0]     u_2_mid,
    input  logic                            iter_flag,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DATA_W-1:0]               out_data,
    output logic [1:0]                      out_row,
    output logic [1:0]                      out_col,
    output logic                            out_first,
    output logic                            out_last,
    output logic [CNT_W-1:0]                out_iter,
    output logic                            overflow,
    output logic [CNT_W-1:0]                drop_count
);

    typedef enum logic [0:0] {StIdle, StStream} state_e;

    state_e                          state_q, state_d;
    logic                            flag_q;
    logic [CNT_W-1:0]                iter_cnt_q, iter_cnt_d;
    logic [1:0]                      full_q, full_d, full_rel;
    logic                            oldest_q, oldest_d;
    logic                            cur_q, cur_d;
    logic [3:0]                      idx_q, idx_d;
    logic [1:0][CNT_W-1:0]           tag_q;
    logic [1:0][3:0][3:0][DATA_W-1:0] mem_q;
    logic [CNT_W-1:0]                drop_q, drop_d;
    logic                            ovf_q, ovf_d;

    logic                            valid_q, valid_d, first_q, first_d, last_q, last_d;
    logic [DATA_W-1:0]               data_q, data_d;
    logic [1:0]                      row_q, row_d, col_q, col_d;
    logic [CNT_W-1:0]                oiter_q, oiter_d;

    logic cap, cap_wr, phase_ok, accept, rel, wr_en, wr_bank, drop, load, from_grid, rd_bank;
    logic [3:0] rd_idx;

    assign cap = iter_flag & ~flag_q;

`ifdef PATCH_READOUT_DECIMATE_EN
    localparam int unsigned PhW = (DECIM > 1) ? $clog2(DECIM) : 1;
    logic [PhW-1:0] phase_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            phase_q <= '0;
        end else if (cap) begin
            phase_q <= (phase_q == PhW'(DECIM - 1)) ? '0 : phase_q + 1'b1;
        end
    end
    assign phase_ok = (phase_q == '0);
`else
    logic unused_decim;
    assign unused_decim = ^DECIM;
    assign phase_ok     = 1'b1;
`endif

    always_comb begin
        accept     = valid_q & out_ready;
        rel        = accept & (idx_q == 4'd15);
        full_rel   = full_q;
        if (rel) full_rel[cur_q] = 1'b0;
        iter_cnt_d = iter_cnt_q + CNT_W'(cap);
        cap_wr     = cap & phase_ok;
        // Release is applied before capture, so a frame can land in the bank just freed.
        wr_en      = cap_wr & ~(&full_rel);
        wr_bank    = full_rel[0];
        drop       = cap_wr & (&full_rel);
        full_d     = full_rel;
        if (wr_en) full_d[wr_bank] = 1'b1;
        oldest_d   = oldest_q;
        if (rel) oldest_d = ~cur_q;
        if (wr_en && !full_rel[~wr_bank]) oldest_d = wr_bank;
        ovf_d      = ovf_q | drop;
        drop_d     = (drop && !(&drop_q)) ? drop_q + 1'b1 : drop_q;

        state_d    = state_q;
        cur_d      = cur_q;
        idx_d      = idx_q;
        valid_d    = valid_q;
        data_d     = data_q;
        row_d      = row_q;
        col_d      = col_q;
        first_d    = first_q;
        last_d     = last_q;
        oiter_d    = oiter_q;
        rd_bank    = cur_q;
        rd_idx     = idx_q;
        load       = 1'b0;
        from_grid  = 1'b0;

        if (state_q == StIdle || rel) begin
            if (|full_rel) begin
                rd_bank = full_rel[oldest_q] ? oldest_q : ~oldest_q;
                rd_idx  = 4'd0;
                load    = 1'b1;
            end else if (wr_en) begin
                // Bank is written this same edge; bypass the grid for sample (0,0).
                rd_bank   = wr_bank;
                rd_idx    = 4'd0;
                load      = 1'b1;
                from_grid = 1'b1;
            end else if (rel) begin
                state_d = StIdle;
                valid_d = 1'b0;
            end
        end else if (accept) begin
            rd_idx = idx_q + 4'd1;
            load   = 1'b1;
        end

        if (load) begin
            state_d = StStream;
            valid_d = 1'b1;
            cur_d   = rd_bank;
            idx_d   = rd_idx;
            data_d  = from_grid ? u_2_mid[0][0] : mem_q[rd_bank][rd_idx[3:2]][rd_idx[1:0]];
            oiter_d = from_grid ? iter_cnt_d : tag_q[rd_bank];
            row_d   = rd_idx[3:2];
            col_d   = rd_idx[1:0];
            first_d = (rd_idx == 4'd0);
            last_d  = (rd_idx == 4'd15);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            flag_q     <= 1'b0;
            iter_cnt_q <= '0;
            full_q     <= '0;
            oldest_q   <= 1'b0;
            cur_q      <= 1'b0;
            idx_q      <= '0;
            drop_q     <= '0;
            ovf_q      <= 1'b0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            row_q      <= '0;
            col_q      <= '0;
            first_q    <= 1'b0;
            last_q     <= 1'b0;
            oiter_q    <= '0;
        end else begin
            state_q    <= state_d;
            flag_q     <= iter_flag;
            iter_cnt_q <= iter_cnt_d;
            full_q     <= full_d;
            oldest_q   <= oldest_d;
            cur_q      <= cur_d;
            idx_q      <= idx_d;
            drop_q     <= drop_d;
            ovf_q      <= ovf_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            row_q      <= row_d;
            col_q      <= col_d;
            first_q    <= first_d;
            last_q     <= last_d;
            oiter_q    <= oiter_d;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_bank] <= u_2_mid;
            tag_q[wr_bank] <= iter_cnt_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_data   = data_q;
    assign out_row    = row_q;
    assign out_col    = col_q;
    assign out_first  = first_q;
    assign out_last   = last_q;
    assign out_iter   = oiter_q;
    assign overflow   = ovf_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_patch_readout_streamer.sv
// Directed bench for patch_readout_streamer; expected samples are queued at capture time and
// popped on each accepted output beat.
module tb_patch_readout_streamer;

    localparam int DW = 18;
    localparam int CW = 16;

    logic                        clock = 1'b0;
    logic                        reset;
    logic [3:0][3:0][DW-1:0]     u_2_mid;
    logic                        iter_flag;
    logic                        out_valid;
    logic                        out_ready;
    logic [DW-1:0]               out_data;
    logic [1:0]                  out_row;
    logic [1:0]                  out_col;
    logic                        out_first;
    logic                        out_last;
    logic [CW-1:0]               out_iter;
    logic                        overflow;
    logic [CW-1:0]               drop_count;

    patch_readout_streamer dut (
        .clock      (clock),
        .reset      (reset),
        .u_2_mid    (u_2_mid),
        .iter_flag  (iter_flag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_row    (out_row),
        .out_col    (out_col),
        .out_first  (out_first),
        .out_last   (out_last),
        .out_iter   (out_iter),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    always #5 clock = ~clock;

    typedef logic [DW+2+2+1+1+CW-1:0] smp_t;

    int   checks   = 0;
    int   failures = 0;
    smp_t sb_q[$];
    smp_t obs_smp;
    smp_t held;
    logic stall_q = 1'b0;

    assign obs_smp = {out_data, out_row, out_col, out_first, out_last, out_iter};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic smp_t mk(input int data, input int r, input int c, input int iter);
        return {DW'(data), 2'(r), 2'(c), (r == 0 && c == 0), (r == 3 && c == 3), CW'(iter)};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_grid(input int base);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                u_2_mid[r][c] = DW'(base + 16 * r + c);
    endtask

    task automatic push_frame(input int base, input int iter);
        for (int i = 0; i < 16; i++)
            sb_q.push_back(mk(base + 16 * (i >> 2) + (i & 3), i >> 2, i & 3, iter));
    endtask

    task automatic pulse();
        iter_flag = 1'b1;
        tick();
        iter_flag = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        iter_flag = 1'b0;
        sb_q.delete();
        repeat (2) tick();
        reset = 1'b0;
    endtask

    // Scoreboard pop on accepted beats, plus hold-while-stalled check.
    always @(negedge clock) begin
        if (reset) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_fields", obs_smp, held);
            end
            if (out_valid && out_ready) begin
                chk("sample_expected", sb_q.size() > 0, 1);
                if (sb_q.size() > 0) chk("sample", obs_smp, sb_q.pop_front());
            end
            stall_q = out_valid && !out_ready;
            held    = obs_smp;
        end
    end

    initial begin
        reset     = 1'b1;
        iter_flag = 1'b0;
        out_ready = 1'b1;
        set_grid(0);
        repeat (3) tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_row", out_row, 0);
        chk("rst_col", out_col, 0);
        chk("rst_first", out_first, 0);
        chk("rst_last", out_last, 0);
        chk("rst_iter", out_iter, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_drops", drop_count, 0);
        reset = 1'b0;
        tick();

        // Single frame, ready high: latency 1, 16 consecutive beats.
        set_grid(0);
        push_frame(0, 1);
        iter_flag = 1'b1;
        tick();
        iter_flag = 1'b0;
        chk("t1_latency_valid", out_valid, 1);
        chk("t1_first", out_first, 1);
        for (int i = 0; i < 16; i++) begin
            chk("t1_stream_valid", out_valid, 1);
            tick();
        end
        chk("t1_idle_after", out_valid, 0);
        chk("t1_sb_empty", sb_q.size(), 0);

        // Flag held high for 5 cycles: one frame only.
        set_grid(256);
        push_frame(256, 2);
        iter_flag = 1'b1;
        repeat (5) tick();
        iter_flag = 1'b0;
        repeat (20) tick();
        chk("t2_idle", out_valid, 0);
        chk("t2_sb_empty", sb_q.size(), 0);

        // Back-pressure: two frames buffered, third dropped.
        do_reset();
        out_ready = 1'b0;
        set_grid(32'h1000);
        push_frame(32'h1000, 1);
        pulse();
        set_grid(32'h2000);
        push_frame(32'h2000, 2);
        pulse();
        set_grid(32'h3000);
        pulse();
        repeat (34) tick();
        chk("t3_overflow", overflow, 1);
        chk("t3_drops", drop_count, 1);
        chk("t3_held_valid", out_valid, 1);
        chk("t3_held_iter", out_iter, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            chk("t3_stream_valid", out_valid, 1);
            tick();
        end
        chk("t3_idle_after", out_valid, 0);
        chk("t3_sb_empty", sb_q.size(), 0);

        // Capture coincides with acceptance of (3,3) while both banks are full.
        do_reset();
        out_ready = 1'b0;
        set_grid(32'h4000);
        push_frame(32'h4000, 1);
        pulse();
        set_grid(32'h5000);
        push_frame(32'h5000, 2);
        pulse();
        set_grid(32'h6000);
        push_frame(32'h6000, 3);
        out_ready = 1'b1;
        for (int i = 0; i < 48; i++) begin
            chk("t4_no_bubble", out_valid, 1);
            iter_flag = (i == 15);
            tick();
        end
        iter_flag = 1'b0;
        chk("t4_idle_after", out_valid, 0);
        chk("t4_drops", drop_count, 0);
        chk("t4_overflow", overflow, 0);
        chk("t4_sb_empty", sb_q.size(), 0);

        // Reset mid-frame at idx 7.
        do_reset();
        out_ready = 1'b1;
        set_grid(32'h7000);
        push_frame(32'h7000, 1);
        iter_flag = 1'b1;
        tick();
        iter_flag = 1'b0;
        repeat (7) tick();
        chk("t5_at_idx7_row", out_row, 1);
        chk("t5_at_idx7_col", out_col, 3);
        out_ready = 1'b0;
        reset     = 1'b1;
        tick();
        chk("t5_rst_valid", out_valid, 0);
        chk("t5_rst_iter", out_iter, 0);
        chk("t5_rst_drops", drop_count, 0);
        chk("t5_rst_overflow", overflow, 0);
        sb_q.delete();
        reset     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            chk("t5_no_stale", out_valid, 0);
            tick();
        end
        set_grid(32'h8000);
        push_frame(32'h8000, 1);
        iter_flag = 1'b1;
        tick();
        iter_flag = 1'b0;
        chk("t5_iter_restart", out_iter, 1);
        repeat (17) tick();
        chk("t5_sb_empty", sb_q.size(), 0);

`ifdef PATCH_READOUT_DECIMATE_EN
        // Decimation by 4: pulses 1 and 5 are kept.
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            set_grid(32'h9000 + k * 32'h100);
            if (k % 4 == 0) push_frame(32'h9000 + k * 32'h100, k + 1);
            pulse();
            repeat (18) tick();
        end
        chk("t6_drops", drop_count, 0);
        chk("t6_sb_empty", sb_q.size(), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
